// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the hardwired CPU control unit: the opcode map
//   (IR[31:27]), the step encoding, the strobe bundle type and two helpers
//   that describe instruction shape (last step, memory-wait steps).
package cpu_ctrl_pkg;

  localparam int OP_W         = 5;
  localparam int MEM_WAIT_MAX = 15;
  localparam int WAIT_CNT_W   = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OP_W-1:0] OP_BRZR = 5'b10010;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } step_t;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, ba_out;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, c_out, hi_in, lo_in, hi_out, lo_out;
    logic con_in, inport_out, outport_in, link_in;
  } ctrl_strobes_t;

  // Final step of each instruction; unknown opcodes finish with the fetch.
  function automatic step_t last_step(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  last_step = S_T5;
      OP_NEG, OP_NOT, OP_JAL:            last_step = S_T4;
      OP_MUL, OP_DIV, OP_BRZR:           last_step = S_T6;
      OP_LD, OP_ST:                      last_step = S_T7;
      OP_JR, OP_MFHI, OP_MFLO, OP_IN,
      OP_OUT:                            last_step = S_T3;
      default:                           last_step = S_T2;
    endcase
  endfunction

  // Steps that hold Read/Write until memory answers.
  function automatic logic is_wait_step(input step_t step, input logic [OP_W-1:0] op);
    is_wait_step = (step == S_T1) ||
                   ((step == S_T6) && (op == OP_LD)) ||
                   ((step == S_T7) && (op == OP_ST));
  endfunction

endpackage

// File: rtl/ctrl_strobe_decode.sv
// ctrl_strobe_decode
//   Purely combinational decode of (step, opcode, con_ff) into the datapath
//   strobe bundle and the ALU function code.
//   Ports: step_i    current sequencer step (HALT gives all-zero strobes)
//          opcode_i  IR[31:27]
//          con_ff_i  branch condition, drives PCin in brzr T6
//          strobes_o strobe bundle
//          alu_op_o  ALU function, nonzero only while Zin is asserted
module ctrl_strobe_decode
  import cpu_ctrl_pkg::*;
(
  input  step_t           step_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            con_ff_i,
  output ctrl_strobes_t   strobes_o,
  output logic [OP_W-1:0] alu_op_o
);

  logic alu_add;  // Zin step computes an address/target, so force add

  always_comb begin
    strobes_o = '0;
    alu_add   = 1'b0;
    case (step_i)
      S_T0: begin strobes_o.pc_out = 1'b1; strobes_o.mar_in = 1'b1; strobes_o.inc_pc = 1'b1; end
      S_T1: begin strobes_o.read = 1'b1; strobes_o.mdr_in = 1'b1; end
      S_T2: begin strobes_o.mdr_out = 1'b1; strobes_o.ir_in = 1'b1; end
      S_HALT: ;
      default: begin
        case (opcode_i)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step_i)
              S_T3: begin strobes_o.grb = 1'b1; strobes_o.rout = 1'b1; strobes_o.y_in = 1'b1; end
              S_T4: begin
                // Register form reads Rc, immediate form takes C-sign-extended
                if (opcode_i inside {OP_ADDI, OP_ANDI, OP_ORI}) strobes_o.c_out = 1'b1;
                else begin strobes_o.grc = 1'b1; strobes_o.rout = 1'b1; end
                strobes_o.z_in = 1'b1;
              end
              S_T5: begin strobes_o.zlow_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.rin = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (step_i)
              S_T3: begin strobes_o.grb = 1'b1; strobes_o.rout = 1'b1; strobes_o.z_in = 1'b1; end
              S_T4: begin strobes_o.zlow_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.rin = 1'b1; end
              default: ;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (step_i)
              S_T3: begin strobes_o.gra = 1'b1; strobes_o.rout = 1'b1; strobes_o.y_in = 1'b1; end
              S_T4: begin strobes_o.grb = 1'b1; strobes_o.rout = 1'b1; strobes_o.z_in = 1'b1; end
              S_T5: begin strobes_o.zlow_out = 1'b1; strobes_o.lo_in = 1'b1; end
              S_T6: begin strobes_o.zhigh_out = 1'b1; strobes_o.hi_in = 1'b1; end
              default: ;
            endcase
          end
          OP_LDI, OP_LD, OP_ST: begin
            case (step_i)
              S_T3: begin strobes_o.grb = 1'b1; strobes_o.ba_out = 1'b1; strobes_o.y_in = 1'b1; end
              S_T4: begin strobes_o.c_out = 1'b1; strobes_o.z_in = 1'b1; alu_add = 1'b1; end
              S_T5: begin
                strobes_o.zlow_out = 1'b1;
                if (opcode_i == OP_LDI) begin strobes_o.gra = 1'b1; strobes_o.rin = 1'b1; end
                else strobes_o.mar_in = 1'b1;
              end
              S_T6: begin
                if (opcode_i == OP_LD) begin strobes_o.read = 1'b1; strobes_o.mdr_in = 1'b1; end
                if (opcode_i == OP_ST) begin
                  strobes_o.gra = 1'b1; strobes_o.rout = 1'b1; strobes_o.mdr_in = 1'b1;
                end
              end
              S_T7: begin
                if (opcode_i == OP_LD) begin
                  strobes_o.mdr_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.rin = 1'b1;
                end
                if (opcode_i == OP_ST) strobes_o.write = 1'b1;
              end
              default: ;
            endcase
          end
          OP_BRZR: begin
            case (step_i)
              S_T3: begin strobes_o.gra = 1'b1; strobes_o.rout = 1'b1; strobes_o.con_in = 1'b1; end
              S_T4: begin strobes_o.pc_out = 1'b1; strobes_o.y_in = 1'b1; end
              S_T5: begin strobes_o.c_out = 1'b1; strobes_o.z_in = 1'b1; alu_add = 1'b1; end
              S_T6: begin strobes_o.zlow_out = 1'b1; strobes_o.pc_in = con_ff_i; end
              default: ;
            endcase
          end
          OP_JR: if (step_i == S_T3) begin
            strobes_o.gra = 1'b1; strobes_o.rout = 1'b1; strobes_o.pc_in = 1'b1;
          end
          OP_JAL: begin
            case (step_i)
              S_T3: begin strobes_o.pc_out = 1'b1; strobes_o.link_in = 1'b1; end
              S_T4: begin strobes_o.gra = 1'b1; strobes_o.rout = 1'b1; strobes_o.pc_in = 1'b1; end
              default: ;
            endcase
          end
          OP_MFHI: if (step_i == S_T3) begin
            strobes_o.hi_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.rin = 1'b1;
          end
          OP_MFLO: if (step_i == S_T3) begin
            strobes_o.lo_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.rin = 1'b1;
          end
          OP_IN: if (step_i == S_T3) begin
            strobes_o.inport_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.rin = 1'b1;
          end
          OP_OUT: if (step_i == S_T3) begin
            strobes_o.gra = 1'b1; strobes_o.rout = 1'b1; strobes_o.outport_in = 1'b1;
          end
          default: ;
        endcase
      end
    endcase
    alu_op_o = strobes_o.z_in ? (alu_add ? OP_ADD : opcode_i) : '0;
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit: steps fetch (T0-T2) and execute (T3-T7) sequences,
//   stalls on memory wait steps, times out to HALT with a sticky mem_err, and
//   honours a stop request at the end of an instruction.
//   Ports: clock/reset (sync, active-high), opcode (IR[31:27]), con_ff,
//          mem_ready, stop; register-select, bus, memory and ALU strobes;
//          alu_op; run (0 in HALT); mem_err (sticky until reset).
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            con_ff,
  input  logic            mem_ready,
  input  logic            stop,
  output logic Gra, output logic Grb, output logic Grc,
  output logic Rin, output logic Rout, output logic BAout,
  output logic PCout, output logic PCin, output logic IncPC,
  output logic MARin, output logic MDRin, output logic MDRout,
  output logic Read, output logic Write, output logic IRin,
  output logic Yin, output logic Zin, output logic Zlowout,
  output logic Zhighout, output logic Cout, output logic HIin,
  output logic LOin, output logic HIout, output logic LOout,
  output logic CONin, output logic InPortout, output logic OutPortin,
  output logic link_in,
  output logic [OP_W-1:0] alu_op,
  output logic            run,
  output logic            mem_err
);

  step_t                 step_q, step_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_err_q, mem_err_d;
  logic                  run_q;
  ctrl_strobes_t         strobes;

  always_ff @(posedge clock) begin
    if (reset) begin
      step_q     <= S_T0;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      run_q      <= 1'b1;
    end else begin
      step_q     <= step_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      run_q      <= (step_d != S_HALT);
    end
  end

  // The counter only survives while stalled, so every entry into a wait step
  // starts from zero. The end-of-instruction decision in T2 looks at opcode,
  // so nop/halt/undefined codes must be on the opcode lines by then.
  always_comb begin
    step_d     = step_q;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
    if (step_q == S_HALT) begin
      step_d = S_HALT;
    end else if (is_wait_step(step_q, opcode) && !mem_ready) begin
      if (wait_cnt_q == WAIT_CNT_W'(MEM_WAIT_MAX - 1)) begin
        step_d    = S_HALT;
        mem_err_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else if ((step_q == last_step(opcode)) || (step_q == S_T7)) begin
      step_d = (stop || (opcode == OP_HALT)) ? S_HALT : S_T0;
    end else begin
      step_d = step_t'(step_q + 4'd1);
    end
  end

  ctrl_strobe_decode u_decode (
    .step_i   (step_q),
    .opcode_i (opcode),
    .con_ff_i (con_ff),
    .strobes_o(strobes),
    .alu_op_o (alu_op)
  );

  assign Gra       = strobes.gra;
  assign Grb       = strobes.grb;
  assign Grc       = strobes.grc;
  assign Rin       = strobes.rin;
  assign Rout      = strobes.rout;
  assign BAout     = strobes.ba_out;
  assign PCout     = strobes.pc_out;
  assign PCin      = strobes.pc_in;
  assign IncPC     = strobes.inc_pc;
  assign MARin     = strobes.mar_in;
  assign MDRin     = strobes.mdr_in;
  assign MDRout    = strobes.mdr_out;
  assign Read      = strobes.read;
  assign Write     = strobes.write;
  assign IRin      = strobes.ir_in;
  assign Yin       = strobes.y_in;
  assign Zin       = strobes.z_in;
  assign Zlowout   = strobes.zlow_out;
  assign Zhighout  = strobes.zhigh_out;
  assign Cout      = strobes.c_out;
  assign HIin      = strobes.hi_in;
  assign LOin      = strobes.lo_in;
  assign HIout     = strobes.hi_out;
  assign LOout     = strobes.lo_out;
  assign CONin     = strobes.con_in;
  assign InPortout = strobes.inport_out;
  assign OutPortin = strobes.outport_in;
  assign link_in   = strobes.link_in;
  assign run       = run_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int WMAX = 15;

  localparam logic [4:0] T_LD = 5'd0, T_LDI = 5'd1, T_ST = 5'd2, T_ADD = 5'd3, T_OR = 5'd10;
  localparam logic [4:0] T_ADDI = 5'd11, T_ORI = 5'd13, T_MUL = 5'd14, T_DIV = 5'd15;
  localparam logic [4:0] T_NEG = 5'd16, T_NOT = 5'd17, T_BRZR = 5'd18, T_JR = 5'd19;
  localparam logic [4:0] T_JAL = 5'd20, T_IN = 5'd21, T_OUT = 5'd22, T_MFHI = 5'd23;
  localparam logic [4:0] T_MFLO = 5'd24, T_NOP = 5'd25, T_HALT = 5'd26;

  localparam logic [27:0] M_GRA = 28'd1 << 0,  M_GRB = 28'd1 << 1,  M_GRC = 28'd1 << 2;
  localparam logic [27:0] M_RIN = 28'd1 << 3,  M_ROUT = 28'd1 << 4, M_BAOUT = 28'd1 << 5;
  localparam logic [27:0] M_PCOUT = 28'd1 << 6, M_PCIN = 28'd1 << 7, M_INCPC = 28'd1 << 8;
  localparam logic [27:0] M_MARIN = 28'd1 << 9, M_MDRIN = 28'd1 << 10, M_MDROUT = 28'd1 << 11;
  localparam logic [27:0] M_READ = 28'd1 << 12, M_WRITE = 28'd1 << 13, M_IRIN = 28'd1 << 14;
  localparam logic [27:0] M_YIN = 28'd1 << 15, M_ZIN = 28'd1 << 16, M_ZLOW = 28'd1 << 17;
  localparam logic [27:0] M_ZHIGH = 28'd1 << 18, M_COUT = 28'd1 << 19, M_HIIN = 28'd1 << 20;
  localparam logic [27:0] M_LOIN = 28'd1 << 21, M_HIOUT = 28'd1 << 22, M_LOOUT = 28'd1 << 23;
  localparam logic [27:0] M_CONIN = 28'd1 << 24, M_INPORT = 28'd1 << 25, M_OUTPORT = 28'd1 << 26;
  localparam logic [27:0] M_LINK = 28'd1 << 27;
  localparam logic [27:0] M_T0 = M_PCOUT | M_MARIN | M_INCPC;

  logic clock = 1'b0, reset = 1'b1, con_ff = 1'b0, mem_ready = 1'b0, stop = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
  logic Read, Write, IRin, Yin, Zin, Zlowout, Zhighout, Cout, HIin, LOin, HIout, LOout;
  logic CONin, InPortout, OutPortin, link_in, run, mem_err;
  logic [4:0] alu_op;
  logic [27:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference micro-program for the current instruction
  logic [27:0] pm[$];
  bit          pw[$];
  logic [4:0]  pa[$];

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .reset(reset), .opcode(opcode), .con_ff(con_ff),
    .mem_ready(mem_ready), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .Cout(Cout), .HIin(HIin), .LOin(LOin),
    .HIout(HIout), .LOout(LOout), .CONin(CONin), .InPortout(InPortout),
    .OutPortin(OutPortin), .link_in(link_in), .alu_op(alu_op), .run(run),
    .mem_err(mem_err)
  );

  assign obs = {link_in, OutPortin, InPortout, CONin, LOout, HIout, LOin, HIin, Cout,
                Zhighout, Zlowout, Zin, Yin, IRin, Write, Read, MDRout, MDRin, MARin,
                IncPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

  function automatic void add_step(input logic [27:0] m, input bit w, input logic [4:0] a);
    pm.push_back(m); pw.push_back(w); pa.push_back(a);
  endfunction

  // Instruction described as an ordered list of steps, straight from the ISA table
  function automatic void build_prog(input logic [4:0] op, input bit con);
    pm.delete(); pw.delete(); pa.delete();
    add_step(M_T0, 0, 0);
    add_step(M_READ | M_MDRIN, 1, 0);
    add_step(M_MDROUT | M_IRIN, 0, 0);
    if (op >= T_ADD && op <= T_OR) begin
      add_step(M_GRB | M_ROUT | M_YIN, 0, 0);
      add_step(M_GRC | M_ROUT | M_ZIN, 0, op);
      add_step(M_ZLOW | M_GRA | M_RIN, 0, 0);
    end else if (op >= T_ADDI && op <= T_ORI) begin
      add_step(M_GRB | M_ROUT | M_YIN, 0, 0);
      add_step(M_COUT | M_ZIN, 0, op);
      add_step(M_ZLOW | M_GRA | M_RIN, 0, 0);
    end else if (op == T_NEG || op == T_NOT) begin
      add_step(M_GRB | M_ROUT | M_ZIN, 0, op);
      add_step(M_ZLOW | M_GRA | M_RIN, 0, 0);
    end else if (op == T_MUL || op == T_DIV) begin
      add_step(M_GRA | M_ROUT | M_YIN, 0, 0);
      add_step(M_GRB | M_ROUT | M_ZIN, 0, op);
      add_step(M_ZLOW | M_LOIN, 0, 0);
      add_step(M_ZHIGH | M_HIIN, 0, 0);
    end else if (op == T_LDI || op == T_LD || op == T_ST) begin
      add_step(M_GRB | M_BAOUT | M_YIN, 0, 0);
      add_step(M_COUT | M_ZIN, 0, T_ADD);
      if (op == T_LDI) add_step(M_ZLOW | M_GRA | M_RIN, 0, 0);
      else add_step(M_ZLOW | M_MARIN, 0, 0);
      if (op == T_LD) begin
        add_step(M_READ | M_MDRIN, 1, 0);
        add_step(M_MDROUT | M_GRA | M_RIN, 0, 0);
      end
      if (op == T_ST) begin
        add_step(M_GRA | M_ROUT | M_MDRIN, 0, 0);
        add_step(M_WRITE, 1, 0);
      end
    end else if (op == T_BRZR) begin
      add_step(M_GRA | M_ROUT | M_CONIN, 0, 0);
      add_step(M_PCOUT | M_YIN, 0, 0);
      add_step(M_COUT | M_ZIN, 0, T_ADD);
      add_step(M_ZLOW | (con ? M_PCIN : 28'd0), 0, 0);
    end else if (op == T_JR) add_step(M_GRA | M_ROUT | M_PCIN, 0, 0);
    else if (op == T_JAL) begin
      add_step(M_PCOUT | M_LINK, 0, 0);
      add_step(M_GRA | M_ROUT | M_PCIN, 0, 0);
    end else if (op == T_MFHI) add_step(M_HIOUT | M_GRA | M_RIN, 0, 0);
    else if (op == T_MFLO) add_step(M_LOOUT | M_GRA | M_RIN, 0, 0);
    else if (op == T_IN) add_step(M_INPORT | M_GRA | M_RIN, 0, 0);
    else if (op == T_OUT) add_step(M_GRA | M_ROUT | M_OUTPORT, 0, 0);
  endfunction

  // Called just after the falling edge of a T0 cycle. Delays >= WMAX mean
  // memory never answers in that wait step.
  task automatic run_instr(input string tag, input logic [4:0] op, input bit con,
                           input bit stop_end, input int fetch_dly, input int exec_dly,
                           output bit halted, output int cycles);
    int n, dly, widx;
    bit to_here, tmo, last_cyc;
    build_prog(op, con);
    opcode = op; con_ff = con;
    halted = 0; cycles = 0; tmo = 0; widx = 0;
    for (int k = 0; k < pm.size() && !tmo; k++) begin
      to_here = 0; n = 1;
      if (pw[k]) begin
        dly = (widx == 0) ? fetch_dly : exec_dly;
        widx++;
        to_here = (dly >= WMAX);
        n = to_here ? WMAX : dly + 1;
      end
      for (int c = 0; c < n; c++) begin
        n_checks++;
        if ({obs, alu_op, run, mem_err} !== {pm[k], pa[k], 1'b1, 1'b0}) begin
          n_errors++;
          $display("FAIL %s step%0d cyc%0d: strobes=%07h alu_op=%0d run=%0b mem_err=%0b, expected strobes=%07h alu_op=%0d run=1 mem_err=0",
                   tag, k, c, obs, alu_op, run, mem_err, pm[k], pa[k]);
        end
        last_cyc = (c == n - 1);
        mem_ready = pw[k] ? (last_cyc && !to_here) : 1'($urandom_range(0, 1));
        stop = (k == pm.size() - 1 && last_cyc) ? stop_end : 1'($urandom_range(0, 1));
        @(negedge clock);
        cycles++;
      end
      tmo = to_here;
    end
    mem_ready = 1'b0; stop = 1'b0;
    if (tmo || stop_end || op == T_HALT) begin
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if ({obs, alu_op, run, mem_err} !== {28'd0, 5'd0, 1'b0, tmo}) begin
          n_errors++;
          $display("FAIL %s halt cyc%0d: strobes=%07h alu_op=%0d run=%0b mem_err=%0b, expected strobes=0 alu_op=0 run=0 mem_err=%0b",
                   tag, c, obs, alu_op, run, mem_err, tmo);
        end
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
      halted = 1;
    end
    $display("instr %s op=%0d con=%0b stop=%0b fdly=%0d xdly=%0d cycles=%0d halted=%0b",
             tag, op, con, stop_end, fetch_dly, exec_dly, cycles, halted);
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1; stop = 1'b1;
    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b0; stop = 1'b0;
    n_checks++;
    if ({obs, run, mem_err} !== {M_T0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL reset: strobes=%07h run=%0b mem_err=%0b, expected strobes=%07h run=1 mem_err=0",
               obs, run, mem_err, M_T0);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    do_reset();
  endtask

  task automatic test_fetch_wait();
    bit h; int cyc;
    do_reset();
    run_instr("fetch_wait_add", T_ADD, 0, 0, 2, 0, h, cyc);
    n_checks++;
    if (cyc !== 8) begin
      n_errors++;
      $display("FAIL fetch_wait_cycles: got %0d, expected 8", cyc);
    end
  endtask

  task automatic test_add();
    bit h; int cyc;
    do_reset();
    run_instr("add", T_ADD, 0, 0, 0, 0, h, cyc);
    run_instr("add_next", T_NOP, 0, 0, 0, 0, h, cyc);
  endtask

  task automatic test_ld();
    bit h; int cyc;
    do_reset();
    run_instr("ld", T_LD, 0, 0, 0, 1, h, cyc);
    n_checks++;
    if (cyc !== 9) begin
      n_errors++;
      $display("FAIL ld_cycles: got %0d, expected 9", cyc);
    end
    run_instr("st", T_ST, 1, 0, 0, 3, h, cyc);
  endtask

  task automatic test_brzr();
    bit h; int cyc;
    do_reset();
    run_instr("brzr_c0", T_BRZR, 0, 0, 0, 0, h, cyc);
    run_instr("brzr_c1", T_BRZR, 1, 0, 1, 0, h, cyc);
  endtask

  task automatic test_halt_stop();
    bit h; int cyc;
    do_reset();
    run_instr("halt_op", T_HALT, 0, 0, 0, 0, h, cyc);
    do_reset();
    run_instr("stop_add", T_ADD, 0, 1, 0, 0, h, cyc);
    do_reset();
    run_instr("stop_st", T_ST, 0, 1, 1, 2, h, cyc);
  endtask

  task automatic test_timeout();
    bit h; int cyc;
    do_reset();
    run_instr("timeout_fetch", T_ADD, 0, 0, WMAX, 0, h, cyc);
    do_reset();
    run_instr("timeout_ld", T_LD, 0, 0, 0, WMAX, h, cyc);
    do_reset();
    run_instr("ready_on_last", T_LD, 0, 0, WMAX - 1, WMAX - 1, h, cyc);
  endtask

  task automatic test_reset_mid_wait();
    bit h; int cyc;
    do_reset();
    opcode = T_LD; con_ff = 1'b0;
    mem_ready = 1'b1;
    repeat (6) @(negedge clock);
    mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (obs !== (M_READ | M_MDRIN)) begin
      n_errors++;
      $display("FAIL ld_t6_wait: strobes=%07h, expected %07h", obs, M_READ | M_MDRIN);
    end
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b0;
    n_checks++;
    if ({obs, Read, run, mem_err} !== {M_T0, 1'b0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_mid_wait: strobes=%07h Read=%0b run=%0b mem_err=%0b, expected strobes=%07h Read=0 run=1 mem_err=0",
               obs, Read, run, mem_err, M_T0);
    end
    run_instr("after_mid_reset", T_LD, 0, 0, 0, 0, h, cyc);
  endtask

  task automatic test_back_to_back();
    bit h; int cyc;
    logic [4:0] op;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      op = 5'($urandom_range(0, 31));
      run_instr("rand", op, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3), $urandom_range(0, 3), h, cyc);
      if (h) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_add();
    test_ld();
    test_brzr();
    test_halt_stop();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
